// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: synchronizes raw device requests into edge/level pending bits gated by enable
module irq_source_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] dev_irq,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [NSRC-1:0] interrupt,
  output logic            irq_any
);
  logic [NSRC-1:0] s1_q, s2_q, s3_q, pend_q, en_q, mode_q, int_q;
  logic [NSRC-1:0] pend_d, en_d, mode_d, rise, clr, edge_m;
  logic            any_q, unused_wd;
  assign unused_wd = ^wd[31:NSRC];
  // a bit in edge mode before or after a MODE write keeps its value at the write edge
  always_comb begin
    rise   = s2_q & ~s3_q;
    clr    = (we && addr == 2'd0) ? wd[NSRC-1:0] : '0;
    en_d   = (we && addr == 2'd1) ? wd[NSRC-1:0] : en_q;
    mode_d = (we && addr == 2'd2) ? wd[NSRC-1:0] : mode_q;
    edge_m = mode_q | mode_d;
    pend_d = (edge_m & (rise | (pend_q & ~clr))) | (~edge_m & s2_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      int_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      s1_q   <= dev_irq;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      int_q  <= pend_q & en_q;
      any_q  <= |(pend_q & en_q);
    end
  end
  always_comb rd = addr == 2'd0 ? 32'(pend_q) :
                   addr == 2'd1 ? 32'(en_q) :
                   addr == 2'd2 ? 32'(mode_q) : 32'(s2_q);
  assign interrupt = int_q;
  assign irq_any   = any_q;
endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed checks of latency, W1C, enable gating, level mode and async reset
module tb_irq_source_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  dev_irq = '0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [5:0]  interrupt;
  logic        irq_any;
  int          tests = 0;
  int          fails = 0;
  irq_source_ctrl #(.NSRC(6)) dut (
    .clk(clk), .rst(rst), .dev_irq(dev_irq), .we(we), .addr(addr),
    .wd(wd), .rd(rd), .interrupt(interrupt), .irq_any(irq_any)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(tag, rd, exp);
  endtask
  initial begin
    #100000 $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    #1 check("rst_int", 32'(interrupt), 0);
    check("rst_any", 32'(irq_any), 0);
    rdchk("rst_en", 2'd1, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h01);
    dev_irq = 6'h01;
    cyc(1); rdchk("lat_e0_pend", 2'd0, 0);
    cyc(1); rdchk("lat_e1_pend", 2'd0, 0);
    cyc(1); rdchk("lat_e2_pend", 2'd0, 32'h01);
    check("lat_e2_int", 32'(interrupt), 0);
    cyc(1); check("lat_e3_int", 32'(interrupt), 32'h01);
    check("lat_e3_any", 32'(irq_any), 1);
    dev_irq = 6'h00;
    cyc(4); check("hold_int", 32'(interrupt), 32'h01);
    wr(2'd0, 32'h01);
    rdchk("w1c_pend", 2'd0, 0);
    check("w1c_int_e", 32'(interrupt), 32'h01);
    cyc(1); check("w1c_int_e1", 32'(interrupt), 0);
    check("w1c_any_e1", 32'(irq_any), 0);
    dev_irq = 6'h01;
    cyc(2);
    wr(2'd0, 32'h01);
    rdchk("set_wins_pend", 2'd0, 32'h01);
    cyc(1); check("set_wins_int", 32'(interrupt), 32'h01);
    wr(2'd0, 32'h01);
    rdchk("coalesce_clr", 2'd0, 0);
    dev_irq = 6'h00;
    wr(2'd2, 32'h00);
    wr(2'd1, 32'h04);
    cyc(3);
    dev_irq = 6'h04;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check($sformatf("level_int_k%0d", k), 32'(interrupt & 6'h04), (k >= 3 && k <= 7) ? 32'h04 : 0);
      if (k == 3) begin we = 1'b1; addr = 2'd0; wd = 32'h04; end
      if (k == 4) begin we = 1'b0; dev_irq = 6'h00; end
    end
    wr(2'd2, 32'h3F);
    wr(2'd1, 32'h20);
    dev_irq = 6'h21;
    cyc(4);
    rdchk("gate_pend", 2'd0, 32'h21);
    check("gate_int", 32'(interrupt), 32'h20);
    check("gate_any", 32'(irq_any), 1);
    wr(2'd1, 32'h3F);
    check("reen_int_e", 32'(interrupt), 32'h20);
    cyc(1); check("reen_int_e1", 32'(interrupt), 32'h21);
    dev_irq = 6'h3F;
    cyc(4); check("all_int", 32'(interrupt), 32'h3F);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("arst_int", 32'(interrupt), 0);
    check("arst_any", 32'(irq_any), 0);
    rdchk("arst_pend", 2'd0, 0);
    rdchk("arst_en", 2'd1, 0);
    rdchk("arst_mode", 2'd2, 0);
    rdchk("arst_raw", 2'd3, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(3);
    rdchk("post_rst_level_pend", 2'd0, 32'h3F);
    check("post_rst_int_gated", 32'(interrupt), 0);
    dev_irq = 6'h00;
    cyc(3);
    rdchk("level_drop_pend", 2'd0, 0);
    wr(2'd2, 32'h20);
    wr(2'd1, 32'hFFFF_FFFF);
    rdchk("en_upper_zero", 2'd1, 32'h3F);
    @(posedge clk);
    #2 dev_irq = 6'h20;
    #4 dev_irq = 6'h00;
    @(negedge clk);
    cyc(4);
    rdchk("glitch_pend", 2'd0, 0);
    dev_irq = 6'h20;
    cyc(2);
    rdchk("raw_s2", 2'd3, 32'h20);
    dev_irq = 6'h00;
    cyc(3);
    rdchk("held_pend", 2'd0, 32'h20);
    wr(2'd3, 32'h1F);
    rdchk("wr3_en", 2'd1, 32'h3F);
    rdchk("wr3_mode", 2'd2, 32'h20);
    rdchk("wr3_pend", 2'd0, 32'h20);
    cyc(1); check("held_int", 32'(interrupt), 32'h20);
    check("held_any", 32'(irq_any), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_source_ctrl.md
IRQ_SOURCE_CTRL -- requirements
Module: irq_source_ctrl

Interface
REQ-001 Parameter: NSRC, default 6, number of interrupt sources; matches the CP0 interrupt input width.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 dev_irq  input  NSRC  raw peripheral requests, asynchronous to clk.
REQ-005 we  input  1  register write enable, sampled on the rising clk edge.
REQ-006 addr  input  2  register select: 0 PENDING, 1 ENABLE, 2 MODE, 3 RAW.
REQ-007 wd  input  32  write data; bits [NSRC-1:0] used, others ignored.
REQ-008 rd  output  32  combinational read data for addr; bits [31:NSRC] read 0.
REQ-009 interrupt  output  NSRC  registered request lines to the CP0 interrupt input.
REQ-010 irq_any  output  1  registered OR of interrupt.

Function
REQ-011 Each dev_irq[i] SHALL pass through a two-flop synchronizer (s1, s2) plus a history flop s3 (s3<=s2).
REQ-012 Edge detect SHALL be edge[i] = s2[i] & ~s3[i]; it SHALL be high for one cycle per rising edge.
REQ-013 MODE[i]=1 (edge): pending[i] SHALL set on edge[i] and hold until cleared by software.
REQ-014 MODE[i]=0 (level): pending[i] SHALL equal the registered s2[i] each cycle; software clear has no effect.
REQ-015 Write to addr 0 SHALL be write-1-to-clear on pending; written 0 bits leave pending unchanged.
REQ-016 Edge mode, same cycle edge[i] and W1C of bit i: set SHALL win; pending[i] stays 1.
REQ-017 Write to addr 1 SHALL load ENABLE[NSRC-1:0] from wd; ENABLE gates output only, never pending.
REQ-018 Write to addr 2 SHALL load MODE[NSRC-1:0]; on a 1->0 MODE change, pending[i] SHALL follow s2[i] from the next cycle.
REQ-019 On a 0->1 MODE change, pending[i] SHALL retain its current value; only later edges set it.
REQ-020 Writes to addr 3 SHALL be ignored; a read of addr 3 SHALL return s2.
REQ-021 Reads SHALL return PENDING, ENABLE, MODE or s2 per addr, with no side effects.
REQ-022 interrupt SHALL be registered as pending & ENABLE; irq_any SHALL be registered as |(pending & ENABLE).
REQ-023 Latency: a dev_irq[i] first sampled high at edge E0 SHALL set pending[i] at E2 and interrupt[i] at E3, given ENABLE[i]=1.
REQ-024 Clearing ENABLE[i] at edge E SHALL drop interrupt[i] at E+1; pending[i] stays set, so re-enabling re-asserts interrupt[i].
REQ-025 A W1C at edge E SHALL drop interrupt[i] at E+1, unless REQ-016 applies.
REQ-026 Edge mode: pulses on dev_irq[i] shorter than one clk period MAY be missed; pulses held for at least 2 periods SHALL be captured.
REQ-027 Edge mode: repeated edges while pending[i]=1 SHALL be coalesced with no count or overflow.
REQ-028 The block SHALL have no combinational path from dev_irq to any output.

Reset
REQ-029 While rst=1: s1, s2, s3, pending, ENABLE, MODE, interrupt and irq_any SHALL be 0 immediately, independent of clk.
REQ-030 After rst deasserts, a dev_irq already high SHALL be seen as a rising edge, because s3=0.
REQ-031 In level mode after rst deasserts, a dev_irq already high SHALL be captured as pending.
REQ-032 If rst asserts mid-operation, all pending requests SHALL be discarded.

Verification
REQ-033 Reset; ENABLE=0x3F, MODE=0x01; dev_irq[0] 0->1 held -> pending=0x01 at E2, interrupt=0x01 and irq_any=1 at E3; interrupt stays 0x01 after dev_irq drops.
REQ-034 Edge-mode source pending; write addr0=0x01 -> interrupt[0]=0 next cycle; repeat the write on the same cycle as a new edge -> pending[0] remains 1.
REQ-035 MODE=0, ENABLE=0x04; dev_irq[2] high 5 cycles -> interrupt[2] high 5 cycles, lagging by 3 edges; W1C of 0x04 has no effect.
REQ-036 pending=0x21, ENABLE=0x20 -> interrupt=0x20; write ENABLE=0x3F -> interrupt=0x21 next cycle.
REQ-037 Assert rst asynchronously mid-clock with interrupt=0x3F -> all outputs 0 before the next clk edge; rd at addr 1 and addr 2 = 0.
REQ-038 dev_irq[5] 1-cycle glitch, then held 2 cycles in edge mode -> only the held pulse sets pending[5]; reading addr3 returns s2 and writing addr3 changes nothing.
